// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver with start-glitch rejection,
// framing-error reporting and break handling. Frames are 1 start bit,
// NB_DATA data bits (LSB first) and one stop bit.
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic               o_rx_done,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_frame_err
);

  localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  // Tick counts at which the FSM acts: mid start bit, end of a data bit,
  // and the stop-bit sampling point.
  localparam logic [3:0]        START_MID = 4'd7;
  localparam logic [3:0]        BIT_END   = 4'd15;
  localparam logic [3:0]        STOP_END  = 4'(SB_TICK - 1);
  localparam logic [NB_CNT-1:0] LAST_BIT  = NB_CNT'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t              state;
  logic [3:0]          s_cnt;
  logic [NB_CNT-1:0]   n_cnt;
  logic [NB_DATA-1:0]  shreg;
  logic                rx_meta;
  logic                rx_s;

  // Two-flop synchroniser for the asynchronous line; idles high so reset
  // never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered done/error pulses and output byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        // Start detection runs every clock so the falling edge is caught
        // with single-clock resolution, not tick resolution.
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end

        // Re-check the line at mid start bit; a high line means a glitch.
        START: begin
          if (i_tick) begin
            if (s_cnt == START_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

        // Counting from mid start bit, every 16th tick lands mid data bit.
        DATA: begin
          if (i_tick) begin
            if (s_cnt == BIT_END) begin
              shreg <= {rx_s, shreg[NB_DATA-1:1]};
              s_cnt <= '0;
              if (n_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + NB_CNT'(1);
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

        // Good stop bit publishes the byte; a low one flags a framing error
        // and parks in BRK so a held-low line reports only once.
        STOP: begin
          if (i_tick) begin
            if (s_cnt == STOP_END) begin
              s_cnt <= '0;
              if (rx_s) begin
                o_data    <= shreg;
                o_rx_done <= 1'b1;
                state     <= IDLE;
              end else begin
                o_frame_err <= 1'b1;
                state       <= BRK;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

        // Wait for the line to return high before hunting for a start bit.
        BRK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage of the UART. Samples the asynchronous `i_rx` line on a 16× oversampling tick and deserialises 8N1-style frames, LSB first. Presents each good byte on `o_data` with a one-cycle `o_rx_done` pulse; the command interface consumes that pulse and byte directly. Flags bad stop bits with `o_frame_err` and rejects start-bit glitches.

## Interface
- `NB_DATA`, default 8: data bits per frame.
- `SB_TICK`, default 16: ticks spent in the stop bit before it is sampled; 16 = 1 stop bit.
- `i_clk`, in, 1: system clock; all logic is on the rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_rx`, in, 1: asynchronous serial line; idle = 1.
- `i_tick`, in, 1: baud×16 enable from the baud generator; one `i_clk` cycle wide.
- `o_rx_done`, out, 1: one-cycle pulse; a good byte is on `o_data`.
- `o_data`, out, NB_DATA: last good byte received; held until the next good frame.
- `o_frame_err`, out, 1: one-cycle pulse; the stop bit was sampled as 0.

## Operation
- **Input synchroniser:** `i_rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised value `rx_s`.
- **Counters:** `s_cnt` (4 bits) counts ticks; `n_cnt` (log2 NB_DATA bits) counts data bits; `shreg` (NB_DATA bits) is the shift register.
- **Counting rule:** counters change only in cycles with `i_tick`=1. The only action without a tick is start detection in IDLE.
- **IDLE:** when `rx_s`=0, go to START and clear `s_cnt`. This check runs every clock, not only on ticks.
- **START:** on a tick with `s_cnt`=7 (mid start bit):
  - `rx_s`=0: go to DATA; clear `s_cnt` and `n_cnt`.
  - `rx_s`=1: glitch; return to IDLE with no output.
  - Otherwise each tick increments `s_cnt`.
- **DATA:** on a tick with `s_cnt`=15:
  - Shift: `shreg` = {`rx_s`, `shreg`[NB_DATA-1:1]} (LSB arrives first).
  - Clear `s_cnt`.
  - If `n_cnt`=NB_DATA-1, go to STOP; otherwise increment `n_cnt`.
- **STOP:** on a tick with `s_cnt`=SB_TICK-1:
  - `rx_s`=1: load `o_data` from `shreg`, pulse `o_rx_done`, go to IDLE.
  - `rx_s`=0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. A held-low line (break) therefore yields exactly one `o_frame_err` and no spurious frames.
- `o_rx_done` and `o_frame_err` are never asserted together.
- **Reset values:** state=IDLE, all counters 0, `shreg`=0, `o_data`=0, `o_rx_done`=0, `o_frame_err`=0, synchroniser=1.

## Timing
- All outputs are registered.
- `o_rx_done` and `o_frame_err` go high in the cycle after the clock edge that samples the stop bit, and stay high for exactly one cycle.
- `o_data` changes in the same cycle `o_rx_done` goes high and is stable for at least the rest of the next frame.
- **Input latency:** 2 `i_clk` cycles from an `i_rx` edge to `rx_s`.
- **Frame latency:** from entering START to the done pulse is 8 + 16·NB_DATA + SB_TICK ticks (152 ticks for the defaults), plus 1 clock.
- **Sampling point:** every data bit and the stop bit are sampled at mid-bit, 8 ticks after the start falling edge plus 16·k ticks.
- **Frame spacing:** the FSM is back in IDLE mid stop bit. A new start edge immediately after the stop bit is accepted, so back-to-back frames need no extra idle time.
- **No ticks:** if `i_tick` stays 0 mid-frame, state and counters freeze indefinitely.
- **Reset mid-frame:** the async assert clears everything at once; no pulse is emitted for the aborted frame.
- Ticks that arrive while in IDLE or BREAK have no effect.

## Test plan
- **Basic byte:** `i_tick` every 4 clocks; send 0xA5 with a good stop bit. Expect one `o_rx_done` pulse, `o_data`=0xA5, `o_frame_err`=0, and the pulse 152 ticks (+ sync) after the start edge.
- **Start glitch:** drive `i_rx` low for 3 ticks, then high. Expect no `o_rx_done` or `o_frame_err`; a following 0x3C is then received correctly.
- **Framing error and break:** send 0x5A with the stop bit = 0. Expect one `o_frame_err`, no `o_rx_done`, `o_data` still holding the previous 0xA5. Then hold the line low for 400 ticks: no further pulses. Release the line and send 0x81: expect `o_rx_done` with `o_data`=0x81.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Expect two `o_rx_done` pulses with data 0x00 then 0xFF, and `o_data` stable between them.
- **Reset mid-frame:** pull `i_reset` low during data bit 4 of 0x77. Expect outputs 0 immediately and no pulse. After release, 0x77 sent again is received.
- **Tick stall:** send 0xC3, holding `i_tick`=0 for 1000 clocks during bit 2. Expect no corruption when ticks resume; `o_data`=0xC3 with one `o_rx_done` pulse.
